// File: rtl/mult_nxn_pipe_pkg.sv
// mult_pkg: shared helpers for the pipelined NxN multiplier (sizing, latency, config check).
package mult_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lat_of(input int w, input int d);
        return 3 + clog2(w / d);
    endfunction

    function automatic bit cfg_ok(input int w, input int d);
        int r;
        r = (d > 0) ? w / d : 0;
        return (d > 0) && (w % d == 0) && (r >= 2) && ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/mult_nxn_pipe_dxd.sv
// mult_dxd: unsigned DIGITxDIGIT combinational multiplier, one per digit pair.
module mult_dxd #(
    parameter int D = 8
) (
    input  logic [D-1:0]   a_i,
    input  logic [D-1:0]   b_i,
    output logic [2*D-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/mult_nxn_pipe.sv
// mult_nxn_pipe: fully pipelined NxN signed/unsigned multiplier with valid/ready and tag.
// Digit products -> row sums -> binary adder tree; output register holds under backpressure.
module mult_nxn_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int R  = WIDTH / DIGIT;
    localparam int NS = lat_of(WIDTH, DIGIT);
    localparam int P  = 2 * WIDTH;

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
        $error("mult_nxn_pipe: WIDTH must be DIGIT times a power of two >= 2");
    end

    logic               en;
    logic [NS:1]        v_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sgn_q;
    logic [TAG_W-1:0]   tag_q [1:NS];
    logic [WIDTH-1:0]   cor_d;
    logic [WIDTH-1:0]   cor_q [2:NS-1];
    logic [2*DIGIT-1:0] pp_d  [R*R];
    logic [2*DIGIT-1:0] pp_q  [R*R];
    logic [P-1:0]       tr_d  [1:2*R-1];
    logic [P-1:0]       tr_q  [1:2*R-1];

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign busy     = (|v_q) || out_valid;

    genvar i, j;
    for (i = 0; i < R; i++) begin : g_row
        for (j = 0; j < R; j++) begin : g_col
            mult_dxd #(.D(DIGIT)) u_dxd (
                .a_i(a_q[i*DIGIT +: DIGIT]),
                .b_i(b_q[j*DIGIT +: DIGIT]),
                .p_o(pp_d[i*R+j])
            );
        end
    end

    // Upper-half correction, pre-negated so the root stage simply adds it.
    always_comb begin
        cor_d = WIDTH'(0) - (sgn_q && a_q[WIDTH-1] ? b_q : '0) - (sgn_q && b_q[WIDTH-1] ? a_q : '0);
        for (int r = 0; r < R; r++) begin
            tr_d[R+r] = '0;
            for (int c = 0; c < R; c++)
                tr_d[R+r] = tr_d[R+r] + (P'(pp_q[r*R+c]) << ((r + c) * DIGIT));
        end
        for (int n = 1; n < R; n++)
            tr_d[n] = tr_q[2*n] + tr_q[2*n+1];
        tr_d[1] = tr_d[1] + {cor_q[NS-1], {WIDTH{1'b0}}};
    end

    // Heap-ordered tree: leaves R..2R-1 are S3 row sums, node 1 is the last stage.
    always_ff @(posedge clk) begin
        if (en) begin
            a_q      <= in_a;
            b_q      <= in_b;
            sgn_q    <= in_signed;
            tag_q[1] <= in_tag;
            for (int s = 2; s <= NS; s++)
                tag_q[s] <= tag_q[s-1];
            pp_q     <= pp_d;
            cor_q[2] <= cor_d;
            for (int s = 3; s < NS; s++)
                cor_q[s] <= cor_q[s-1];
            tr_q     <= tr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (en) begin
            v_q        <= {v_q[NS-1:1], in_valid};
            out_valid  <= v_q[NS];
            out_result <= tr_q[1];
            out_tag    <= tag_q[NS];
        end
    end

endmodule

// File: tb/tb_mult_nxn_pipe.sv
// tb_mult_nxn_pipe: directed vector table plus streaming, backpressure and reset sequences.
module tb_mult_nxn_pipe;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic         sgn;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 0;
    logic         rst = 1;
    logic         in_valid = 0, in_ready, in_signed = 0, out_valid, out_ready = 1, busy;
    logic [63:0]  in_a = '0, in_b = '0;
    logic [3:0]   in_tag = '0, out_tag;
    logic [127:0] out_result;

    logic         in_valid16 = 0, in_ready16, in_signed16 = 0, out_valid16, busy16;
    logic [15:0]  in_a16 = '0, in_b16 = '0;
    logic [3:0]   in_tag16 = '0, out_tag16;
    logic [31:0]  out_result16;

    int checks = 0, errors = 0, cyc = 0;
    int got, stall_seen, first_cyc, last_cyc;
    bit mon_en = 0, held = 0;
    logic [127:0] h_res;
    logic [3:0]   h_tag;
    logic [127:0] exp_q[$];
    logic [3:0]   etag_q[$];
    vec_t vt[8];
    vec_t v16[4];

    mult_nxn_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    mult_nxn_pipe #(.WIDTH(16), .DIGIT(4), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_signed(in_signed16), .in_tag(in_tag16),
        .out_valid(out_valid16), .out_ready(1'b1), .out_result(out_result16),
        .out_tag(out_tag16), .busy(busy16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [127:0] xe, ye;
        xe = s ? {{64{x[63]}}, x} : {64'b0, x};
        ye = s ? {{64{y[63]}}, y} : {64'b0, y};
        return xe * ye;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {127'b0, in_ready}, 128'd0);
                if (held) begin
                    chk("stall_result", out_result, h_res);
                    chk("stall_tag", {124'b0, out_tag}, {124'b0, h_tag});
                end
                h_res = out_result;
                h_tag = out_tag;
                held = 1;
                stall_seen++;
            end else
                held = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_result: got %0h expected none", out_result);
                end else begin
                    chk("stream_result", out_result, exp_q.pop_front());
                    chk("stream_tag", {124'b0, out_tag}, {124'b0, etag_q.pop_front()});
                end
                got++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    task automatic run1(input vec_t v);
        int lat;
        in_a = v.a; in_b = v.b; in_signed = v.sgn; in_tag = v.tag; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", 128'(lat), 128'd6);
        chk("result", out_result, v.exp);
        chk("tag", {124'b0, out_tag}, {124'b0, v.tag});
    endtask

    task automatic run16(input vec_t v);
        int lat;
        in_a16 = v.a[15:0]; in_b16 = v.b[15:0]; in_signed16 = v.sgn; in_tag16 = v.tag; in_valid16 = 1;
        @(posedge clk); #1;
        in_valid16 = 0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency16", 128'(lat), 128'd5);
        chk("result16", {96'b0, out_result16}, v.exp);
        chk("tag16", {124'b0, out_tag16}, {124'b0, v.tag});
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic s, input logic [3:0] t);
        int w;
        in_a = x; in_b = y; in_signed = s; in_tag = t; in_valid = 1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        chk("send_ready", {127'b0, in_ready}, 128'd1);
        exp_q.push_back(model(x, y, s));
        etag_q.push_back(t);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain(input int n);
        int w;
        w = 0;
        while (got < n && w < 60) begin @(posedge clk); #1; w++; end
        chk("drain_count", 128'(got), 128'(n));
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 4'd2, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 4'd3, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd4, 128'd1};
        vt[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd5, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vt[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 4'd6, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vt[6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 4'd7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
        vt[7] = '{64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 4'd8, 128'h1_0000_0000_0000_0000};
        v16[0] = '{64'h8000, 64'h8000, 1'b1, 4'd9, 128'h4000_0000};
        v16[1] = '{64'h8000, 64'h8000, 1'b0, 4'd10, 128'h4000_0000};
        v16[2] = '{64'hFFFF, 64'hFFFF, 1'b1, 4'd11, 128'd1};
        v16[3] = '{64'hFFFF, 64'hFFFF, 1'b0, 4'd12, 128'hFFFE_0001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_result", out_result, 128'd0);
        chk("rst_out_tag", {124'b0, out_tag}, 128'd0);
        rst = 0;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) run1(vt[k]);
        for (int k = 0; k < 4; k++) run16(v16[k]);

        got = 0; first_cyc = -1; stall_seen = 0; mon_en = 1;
        for (int k = 0; k < 8; k++)
            send({$urandom, $urandom}, {$urandom, $urandom}, k[0], 4'(k));
        drain(8);
        chk("stream_consecutive", 128'(last_cyc - first_cyc), 128'd7);

        got = 0; first_cyc = -1; stall_seen = 0;
        fork
            for (int k = 0; k < 12; k++)
                send({$urandom, $urandom}, {$urandom, $urandom}, k[1], 4'(k));
            begin
                repeat (9) @(posedge clk);
                #1 out_ready = 0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain(12);
        chk("stall_cycles", 128'(stall_seen), 128'd5);
        mon_en = 0;

        for (int k = 0; k < 3; k++) send({$urandom, $urandom}, 64'd3, 1'b0, 4'(k));
        exp_q.delete();
        etag_q.delete();
        chk("inflight_busy", {127'b0, busy}, 128'd1);
        rst = 1;
        #1;
        chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("midrst_busy", {127'b0, busy}, 128'd0);
        chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("post_rst_no_result", 128'(seen), 128'd0);
            chk("post_rst_busy", {127'b0, busy}, 128'd0);
        end
        run1(vt[6]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
